// File: rtl/pico_pkg.sv
// Shared definitions for the pico controller: ALU function codes, opcode
// values and the controller state encoding. The ALU uses the same codes.
package pico_pkg;

    // ALU function codes
    localparam int unsigned RA   = 0;
    localparam int unsigned RADD = 1;
    localparam int unsigned RSUB = 2;
    localparam int unsigned RMUL = 3;

    // Instruction opcodes (10-14 are reserved and decode as NOP)
    localparam int unsigned OP_NOP  = 0;
    localparam int unsigned OP_ADD  = 1;
    localparam int unsigned OP_ADDI = 2;
    localparam int unsigned OP_SUB  = 3;
    localparam int unsigned OP_SUBI = 4;
    localparam int unsigned OP_MUL  = 5;
    localparam int unsigned OP_MULI = 6;
    localparam int unsigned OP_IN   = 7;
    localparam int unsigned OP_BEQ  = 8;
    localparam int unsigned OP_J    = 9;
    localparam int unsigned OP_HALT = 15;

    typedef enum logic [2:0] {
        START,
        RUN,
        WAIT_PRESS,
        WAIT_REL,
        HALT
    } state_t;

endpackage

// File: rtl/pico_if.sv
// Controller <-> datapath bundle.
//   master (controller): takes opcode/zero, drives the datapath strobes.
//   slave  (datapath)  : drives opcode/zero, takes the strobes.
interface pico_if #(
    parameter int unsigned OPW = 4,
    parameter int unsigned FW  = 4
) ();
    logic [OPW-1:0] opcode;
    logic           zero;
    logic [FW-1:0]  alu_func;
    logic           imm_sel;
    logic           in_sel;
    logic           reg_we;
    logic           pc_inc;
    logic           pc_load;
    logic           halted;

    modport master (
        input  opcode, zero,
        output alu_func, imm_sel, in_sel, reg_we, pc_inc, pc_load, halted
    );

    modport slave (
        output opcode, zero,
        input  alu_func, imm_sel, in_sel, reg_we, pc_inc, pc_load, halted
    );
endinterface

// File: rtl/btn_sync.sv
// Two-flop synchroniser for the external button strobe.
//   clk, nReset : clock and async active-low clear
//   btn         : raw asynchronous button input
//   btn_s       : button synchronised into clk, two-cycle latency
module btn_sync (
    input  logic clk,
    input  logic nReset,
    input  logic btn,
    output logic btn_s
);
    logic meta;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            meta  <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            meta  <= btn;
            btn_s <= meta;
        end
    end
endmodule

// File: rtl/pico_ctrl.sv
// Multi-cycle control unit for the pico CPU. Decodes the current opcode in
// RUN and sequences the IN instruction around a synchronised button press.
//   clk, nReset : clock and async active-low reset
//   btn         : asynchronous input-strobe button
//   bus         : opcode/zero in, ALU and PC/register strobes out
// Strobes are decoded combinationally from the registered state so that
// they clear as soon as nReset asserts.
module pico_ctrl
    import pico_pkg::*;
#(
    parameter int unsigned OPW = 4,
    parameter int unsigned FW  = 4
) (
    input  logic   clk,
    input  logic   nReset,
    input  logic   btn,
    pico_if.master bus
);
    state_t        state;
    state_t        state_nxt;
    logic          btn_s;
    logic [FW-1:0] alu_func_c;
    logic          imm_sel_c;
    logic          in_sel_c;
    logic          reg_we_c;
    logic          pc_inc_c;
    logic          pc_load_c;
    logic          halted_c;

    btn_sync u_btn_sync (
        .clk    (clk),
        .nReset (nReset),
        .btn    (btn),
        .btn_s  (btn_s)
    );

    // State register
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) state <= START;
        else         state <= state_nxt;
    end

    // Next-state and strobe decode
    always_comb begin
        state_nxt  = state;
        alu_func_c = FW'(RA);
        imm_sel_c  = 1'b0;
        in_sel_c   = 1'b0;
        reg_we_c   = 1'b0;
        pc_inc_c   = 1'b0;
        pc_load_c  = 1'b0;
        halted_c   = 1'b0;

        case (state)
            START: state_nxt = RUN;

            RUN: begin
                case (bus.opcode)
                    OPW'(OP_ADD), OPW'(OP_ADDI): begin
                        alu_func_c = FW'(RADD);
                        imm_sel_c  = (bus.opcode == OPW'(OP_ADDI));
                        reg_we_c   = 1'b1;
                        pc_inc_c   = 1'b1;
                    end
                    OPW'(OP_SUB), OPW'(OP_SUBI): begin
                        alu_func_c = FW'(RSUB);
                        imm_sel_c  = (bus.opcode == OPW'(OP_SUBI));
                        reg_we_c   = 1'b1;
                        pc_inc_c   = 1'b1;
                    end
                    OPW'(OP_MUL), OPW'(OP_MULI): begin
                        alu_func_c = FW'(RMUL);
                        imm_sel_c  = (bus.opcode == OPW'(OP_MULI));
                        reg_we_c   = 1'b1;
                        pc_inc_c   = 1'b1;
                    end
                    OPW'(OP_IN):   state_nxt = WAIT_PRESS;
                    OPW'(OP_BEQ): begin
                        // Compare by subtraction; the datapath reports zero
                        alu_func_c = FW'(RSUB);
                        pc_load_c  = bus.zero;
                        pc_inc_c   = !bus.zero;
                    end
                    OPW'(OP_J):    pc_load_c = 1'b1;
                    OPW'(OP_HALT): state_nxt = HALT;
                    default:       pc_inc_c  = 1'b1;
                endcase
            end

            // Single write on the press edge; WAIT_REL blocks repeats
            WAIT_PRESS: begin
                if (btn_s) begin
                    in_sel_c  = 1'b1;
                    reg_we_c  = 1'b1;
                    state_nxt = WAIT_REL;
                end
            end

            WAIT_REL: begin
                if (!btn_s) begin
                    pc_inc_c  = 1'b1;
                    state_nxt = RUN;
                end
            end

            HALT:    halted_c = 1'b1;

            default: state_nxt = START;
        endcase
    end

    assign bus.alu_func = alu_func_c;
    assign bus.imm_sel  = imm_sel_c;
    assign bus.in_sel   = in_sel_c;
    assign bus.reg_we   = reg_we_c;
    assign bus.pc_inc   = pc_inc_c;
    assign bus.pc_load  = pc_load_c;
    assign bus.halted   = halted_c;
endmodule

// File: tb/tb_pico_ctrl.sv
// Directed bench for pico_ctrl. Inputs change 1 time unit after the rising
// edge; outputs are sampled on the falling edge.
module tb_pico_ctrl;
    import pico_pkg::*;

    localparam int unsigned OPW = 4;
    localparam int unsigned FW  = 4;

    logic clk = 1'b0;
    logic nReset;
    logic btn;
    int   tests = 0;
    int   fails = 0;
    int   we_cnt;

    pico_if #(.OPW(OPW), .FW(FW)) bus ();

    pico_ctrl #(.OPW(OPW), .FW(FW)) dut (
        .clk    (clk),
        .nReset (nReset),
        .btn    (btn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // {alu_func, imm_sel, in_sel, reg_we, pc_inc, pc_load, halted}
    function automatic logic [9:0] obs();
        return {bus.alu_func, bus.imm_sel, bus.in_sel, bus.reg_we,
                bus.pc_inc, bus.pc_load, bus.halted};
    endfunction

    function automatic logic [9:0] ex(input logic [3:0] f, input logic imm,
                                      input logic ins, input logic we,
                                      input logic inc, input logic ld,
                                      input logic h);
        return {f, imm, ins, we, inc, ld, h};
    endfunction

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] x);
        tests++;
        assert (o === x) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, x);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input string tag, input logic [3:0] op, input logic z,
                           input logic [9:0] x);
        step();
        bus.opcode = op;
        bus.zero   = z;
        @(negedge clk);
        check(tag, 32'(obs()), 32'(x));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout tests=%0d", tests);
        $fatal(1, "timeout");
    end

    initial begin
        nReset     = 1'b0;
        btn        = 1'b0;
        bus.opcode = 4'd1;
        bus.zero   = 1'b0;

        // Reset before and across the first edge
        #3;
        check("reset_pre_edge", 32'(obs()), 32'(ex(0, 0, 0, 0, 0, 0, 0)));
        step();
        check("reset_held", 32'(obs()), 32'(ex(0, 0, 0, 0, 0, 0, 0)));
        nReset = 1'b1;
        @(negedge clk);
        check("start_cycle0", 32'(obs()), 32'(ex(0, 0, 0, 0, 0, 0, 0)));
        step();
        @(negedge clk);
        check("run_add_cycle1", 32'(obs()), 32'(ex(1, 0, 0, 1, 1, 0, 0)));

        // RUN decode table
        run_vec("muli",    4'd6,  1'b0, ex(3, 1, 0, 1, 1, 0, 0));
        run_vec("nop",     4'd0,  1'b0, ex(0, 0, 0, 0, 1, 0, 0));
        run_vec("addi",    4'd2,  1'b0, ex(1, 1, 0, 1, 1, 0, 0));
        run_vec("sub",     4'd3,  1'b0, ex(2, 0, 0, 1, 1, 0, 0));
        run_vec("subi",    4'd4,  1'b0, ex(2, 1, 0, 1, 1, 0, 0));
        run_vec("mul",     4'd5,  1'b0, ex(3, 0, 0, 1, 1, 0, 0));
        run_vec("beq_z1",  4'd8,  1'b1, ex(2, 0, 0, 0, 0, 1, 0));
        run_vec("beq_z0",  4'd8,  1'b0, ex(2, 0, 0, 0, 1, 0, 0));
        run_vec("jump",    4'd9,  1'b1, ex(0, 0, 0, 0, 0, 1, 0));
        run_vec("rsv_10",  4'd10, 1'b0, ex(0, 0, 0, 0, 1, 0, 0));
        run_vec("rsv_14",  4'd14, 1'b1, ex(0, 0, 0, 0, 1, 0, 0));

        // IN with a 10-cycle press starting 3 cycles after entry
        run_vec("in_run",  4'd7,  1'b0, ex(0, 0, 0, 0, 0, 0, 0));
        we_cnt = 0;
        for (int e = 0; e < 16; e++) begin
            step();
            bus.opcode = 4'd1;
            btn = (e >= 3 && e < 13);
            @(negedge clk);
            if (bus.reg_we) we_cnt++;
            check($sformatf("in_press_e%0d", e), 32'(obs()),
                  32'(ex(0, 0, e == 5, e == 5, e == 15, 0, 0)));
        end
        check("in_one_write", 32'(we_cnt), 32'd1);
        step();
        @(negedge clk);
        check("in_back_to_run", 32'(obs()), 32'(ex(1, 0, 0, 1, 1, 0, 0)));

        // HALT is absorbing
        run_vec("halt_run", 4'd15, 1'b0, ex(0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 20; i++) begin
            step();
            bus.opcode = 4'($urandom_range(0, 15));
            bus.zero   = 1'($urandom_range(0, 1));
            btn        = 1'($urandom_range(0, 1));
            @(negedge clk);
            check($sformatf("halt_hold_%0d", i), 32'(obs()),
                  32'(ex(0, 0, 0, 0, 0, 0, 1)));
        end
        #2;
        nReset = 1'b0;
        btn    = 1'b0;
        #1;
        check("halt_reset_async", 32'(obs()), 32'(ex(0, 0, 0, 0, 0, 0, 0)));
        step();
        nReset     = 1'b1;
        bus.opcode = 4'd1;
        bus.zero   = 1'b0;
        @(negedge clk);
        check("halt_exit_start", 32'(obs()), 32'(ex(0, 0, 0, 0, 0, 0, 0)));
        step();
        @(negedge clk);
        check("halt_exit_run", 32'(obs()), 32'(ex(1, 0, 0, 1, 1, 0, 0)));

        // Reset mid-WAIT_REL, unaligned to clk, on the release cycle
        run_vec("in2_run", 4'd7, 1'b0, ex(0, 0, 0, 0, 0, 0, 0));
        for (int e = 0; e < 7; e++) begin
            step();
            bus.opcode = 4'd1;
            btn = (e < 4);
            @(negedge clk);
            check($sformatf("in2_e%0d", e), 32'(obs()),
                  32'(ex(0, 0, e == 2, e == 2, e == 6, 0, 0)));
        end
        #2;
        nReset = 1'b0;
        #1;
        check("wrel_reset_async", 32'(obs()), 32'(ex(0, 0, 0, 0, 0, 0, 0)));
        step();
        btn = 1'b1;
        @(negedge clk);
        check("wrel_reset_held", 32'(obs()), 32'(ex(0, 0, 0, 0, 0, 0, 0)));
        step();
        nReset     = 1'b1;
        bus.opcode = 4'd0;
        @(negedge clk);
        check("wrel_start", 32'(obs()), 32'(ex(0, 0, 0, 0, 0, 0, 0)));
        for (int i = 0; i < 4; i++) begin
            step();
            btn = (i < 2);
            @(negedge clk);
            check($sformatf("wrel_no_write_%0d", i), 32'(obs()),
                  32'(ex(0, 0, 0, 0, 1, 0, 0)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
